// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler: FSM states, config word
// field layout and default frame limits.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WIDTH_LSB  = 0;
    localparam int HEIGHT_LSB = 16;
    localparam int FIELD_W    = 16;

    localparam int DEF_MAX_WIDTH       = 640;
    localparam int DEF_MAX_HEIGHT      = 480;
    localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry output register between the compute core's result port and the
// downstream AXI-Stream sink; accepts a result only when the slot is free or draining.
module axis_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready
);

    logic [31:0] data_r;
    logic        valid_r;
    logic        last_r;

    assign in_ready  = enable && (!valid_r || out_ready);
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;

    // Output slot: load on a result handshake, otherwise hold until downstream takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= 32'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (in_valid && in_ready) begin
            data_r  <= in_data;
            valid_r <= 1'b1;
            last_r  <= in_last;
        end else if (out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: takes a width/height config word, issues one job per pixel in
// raster order with bounded outstanding work, and streams results back out in order.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int MAX_WIDTH       = DEF_MAX_WIDTH,
    parameter int MAX_HEIGHT      = DEF_MAX_HEIGHT,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [15:0] job_x,
    output logic [15:0] job_y,
    output logic        job_last,
    output logic        job_valid,
    input  logic        job_ready,
    input  logic [31:0] res_data,
    input  logic        res_valid,
    output logic        res_ready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        cfg_err
);

    localparam int CNT_W = $clog2(MAX_WIDTH * MAX_HEIGHT + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [15:0]      MAX_W_C   = 16'(MAX_WIDTH);
    localparam logic [15:0]      MAX_H_C   = 16'(MAX_HEIGHT);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        width_r;
    logic [15:0]        height_r;
    logic [15:0]        x_r;
    logic [15:0]        y_r;
    logic [OUT_W-1:0]   outstanding_r;
    logic [CNT_W-1:0]   res_cnt_r;
    logic [CNT_W-1:0]   frame_total_r;
    logic               cfg_err_r;

    logic [15:0]        cfg_w_s;
    logic [15:0]        cfg_h_s;
    logic [31:0]        product_s;
    logic               cfg_hs_s;
    logic               cfg_ok_s;
    logic               job_hs_s;
    logic               res_hs_s;
    logic               last_col_s;
    logic               last_row_s;
    logic               res_last_s;
    logic               out_last_hs_s;
    logic               unused_s;

    assign cfg_w_s   = s_axis_tdata[WIDTH_LSB +: FIELD_W];
    assign cfg_h_s   = s_axis_tdata[HEIGHT_LSB +: FIELD_W];
    assign product_s = {16'd0, cfg_w_s} * {16'd0, cfg_h_s};
    assign cfg_ok_s  = (cfg_w_s != 16'd0) && (cfg_h_s != 16'd0) &&
                       (cfg_w_s <= MAX_W_C) && (cfg_h_s <= MAX_H_C);
    assign cfg_hs_s  = s_axis_tvalid && (state_r == IDLE);

    assign last_col_s = (x_r == width_r - 16'd1);
    assign last_row_s = (y_r == height_r - 16'd1);
    assign res_last_s = (res_cnt_r == frame_total_r - CNT_W'(1));

    assign s_axis_tready = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign cfg_err       = cfg_err_r;
    assign job_x         = x_r;
    assign job_y         = y_r;
    assign job_valid     = (state_r == ISSUE) && (outstanding_r < MAX_OUT_C);
    assign job_last      = (state_r == ISSUE) && last_col_s && last_row_s;
    assign job_hs_s      = job_valid && job_ready;
    assign res_hs_s      = res_valid && res_ready;
    assign out_last_hs_s = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Config tlast and the unused upper product bits carry no information here.
    assign unused_s = ^{s_axis_tlast, product_s};

    // Next-state logic for the IDLE -> ISSUE -> DRAIN frame sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_hs_s && cfg_ok_s) state_nxt_s = ISSUE;
                else                      state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (job_hs_s && job_last) state_nxt_s = DRAIN;
                else                      state_nxt_s = ISSUE;
            end
            DRAIN: begin
                if (out_last_hs_s) state_nxt_s = IDLE;
                else               state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Frame geometry, raster position, in-flight and result counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            width_r       <= 16'd0;
            height_r      <= 16'd0;
            x_r           <= 16'd0;
            y_r           <= 16'd0;
            outstanding_r <= '0;
            res_cnt_r     <= '0;
            frame_total_r <= '0;
            cfg_err_r     <= 1'b0;
        end else begin
            cfg_err_r <= cfg_hs_s && !cfg_ok_s;
            if (cfg_hs_s && cfg_ok_s) begin
                width_r       <= cfg_w_s;
                height_r      <= cfg_h_s;
                x_r           <= 16'd0;
                y_r           <= 16'd0;
                outstanding_r <= '0;
                res_cnt_r     <= '0;
                frame_total_r <= product_s[CNT_W-1:0];
            end else begin
                if (job_hs_s) begin
                    if (last_col_s) begin
                        x_r <= 16'd0;
                        y_r <= y_r + 16'd1;
                    end else begin
                        x_r <= x_r + 16'd1;
                    end
                end
                if (res_hs_s) res_cnt_r <= res_cnt_r + CNT_W'(1);
                // A result with nothing outstanding must not underflow the count.
                case ({job_hs_s, res_hs_s && (outstanding_r != '0)})
                    2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
                    2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
                    default: outstanding_r <= outstanding_r;
                endcase
            end
        end
    end

    axis_out_reg u_out (
        .clk       (aclk),
        .reset     (areset),
        .enable    (state_r != IDLE),
        .in_data   (res_data),
        .in_last   (res_last_s),
        .in_valid  (res_valid),
        .in_ready  (res_ready),
        .out_data  (m_axis_tdata),
        .out_valid (m_axis_tvalid),
        .out_last  (m_axis_tlast),
        .out_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: a reference model expands each accepted
// config into expected jobs and beats; a monitor compares what the DUT presents.
module tb_frame_scheduler;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [15:0] job_x;
    logic [15:0] job_y;
    logic        job_last;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        cfg_err;

    frame_scheduler dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .job_x(job_x), .job_y(job_y), .job_last(job_last),
        .job_valid(job_valid), .job_ready(job_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 aclk = ~aclk;

    typedef struct { int x; int y; bit last; } job_t;
    typedef struct { logic [31:0] d; bit last; } beat_t;

    job_t        job_q[$];
    beat_t       out_q[$];
    logic [31:0] pipe_d[$];
    int          pipe_t[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          jobs_issued = 0;
    int          beats_seen = 0;
    int          model_outs = 0;
    int          core_lat = 2;
    bit          core_hold = 1'b0;
    bit          rand_mode = 1'b0;
    logic [31:0] salt = 32'd0;
    int          cyc = 0;

    function automatic logic [31:0] pix(input int x, input int y, input logic [31:0] s);
        logic [31:0] v;
        v = {y[15:0], x[15:0]};
        return v ^ s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a legal config produces W*H jobs in raster order, one beat each.
    task automatic model_frame(input int w, input int h);
        job_t  j;
        beat_t b;
        if (w >= 1 && h >= 1 && w <= 640 && h <= 480) begin
            for (int yy = 0; yy < h; yy++) begin
                for (int xx = 0; xx < w; xx++) begin
                    j.x = xx; j.y = yy; j.last = (xx == w - 1) && (yy == h - 1);
                    job_q.push_back(j);
                    b.d = pix(xx, yy, salt); b.last = j.last;
                    out_q.push_back(b);
                end
            end
        end
    endtask

    task automatic send_cfg(input int w, input int h);
        int n = 0;
        s_axis_tdata  = {h[15:0], w[15:0]};
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            n++;
        end while (!s_axis_tready && n < 200);
        chk("cfg_accept_timeout", 32'(s_axis_tready), 32'd1);
        salt = $urandom;
        model_frame(w, h);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    // Compute core: returns pix(x,y) for each accepted job, in order, after a latency.
    logic        c_jhs, c_rhs, c_rst;
    logic [15:0] c_jx, c_jy;
    int          c_lat;
    always begin
        @(negedge aclk);
        c_jhs = job_valid && job_ready;
        c_jx  = job_x;
        c_jy  = job_y;
        c_rhs = res_valid && res_ready;
        c_rst = areset;
        @(posedge aclk); #1;
        cyc++;
        if (c_rst) begin
            pipe_d.delete();
            pipe_t.delete();
            res_valid = 1'b0;
        end else begin
            if (c_rhs && pipe_d.size() > 0) begin
                void'(pipe_d.pop_front());
                void'(pipe_t.pop_front());
            end
            if (c_jhs) begin
                c_lat = rand_mode ? int'($urandom_range(1, 4)) : core_lat;
                pipe_d.push_back(pix(int'(c_jx), int'(c_jy), salt));
                pipe_t.push_back(cyc + c_lat - 1);
            end
            if (!core_hold && pipe_d.size() > 0 && pipe_t[0] <= cyc) begin
                res_valid = 1'b1;
                res_data  = pipe_d[0];
            end else begin
                res_valid = 1'b0;
            end
        end
    end

    // Random back-pressure on both handshake inputs while rand_mode is set.
    always @(posedge aclk) begin
        if (rand_mode) begin
            #1;
            job_ready     = 1'($urandom_range(0, 1));
            m_axis_tready = 1'($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations on every handshake and checks held outputs.
    bit          prev_js = 1'b0, prev_ms = 1'b0;
    logic [15:0] p_x, p_y;
    logic        p_jl, p_ml;
    logic [31:0] p_md;
    job_t        ej;
    beat_t       eb;
    always @(negedge aclk) begin
        if (areset) begin
            job_q.delete();
            out_q.delete();
            model_outs = 0;
            prev_js = 1'b0;
            prev_ms = 1'b0;
        end else begin
            if (prev_js) begin
                chk("job_hold_valid", 32'(job_valid), 32'd1);
                chk("job_hold_x", 32'(job_x), 32'(p_x));
                chk("job_hold_y", 32'(job_y), 32'(p_y));
                chk("job_hold_last", 32'(job_last), 32'(p_jl));
            end
            if (prev_ms) begin
                chk("out_hold_valid", 32'(m_axis_tvalid), 32'd1);
                chk("out_hold_data", m_axis_tdata, p_md);
                chk("out_hold_last", 32'(m_axis_tlast), 32'(p_ml));
            end
            if (model_outs >= 4) chk("job_valid_at_max", 32'(job_valid), 32'd0);
            if (job_valid && job_ready) begin
                jobs_issued++;
                model_outs++;
                if (job_q.size() == 0) begin
                    chk("job_unexpected", 32'(job_valid), 32'd0);
                end else begin
                    ej = job_q.pop_front();
                    chk("job_x", 32'(job_x), 32'(ej.x));
                    chk("job_y", 32'(job_y), 32'(ej.y));
                    chk("job_last", 32'(job_last), 32'(ej.last));
                end
            end
            if (res_valid && res_ready) model_outs--;
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                if (out_q.size() == 0) begin
                    chk("beat_unexpected", 32'(m_axis_tvalid), 32'd0);
                end else begin
                    eb = out_q.pop_front();
                    chk("beat_data", m_axis_tdata, eb.d);
                    chk("beat_last", 32'(m_axis_tlast), 32'(eb.last));
                end
            end
            prev_js = job_valid && !job_ready;
            prev_ms = m_axis_tvalid && !m_axis_tready;
            p_x = job_x; p_y = job_y; p_jl = job_last;
            p_md = m_axis_tdata; p_ml = m_axis_tlast;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int jb, bb, w, h, n;
    initial begin
        areset = 1'b1; s_axis_tdata = 32'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        job_ready = 1'b1; m_axis_tready = 1'b1; res_valid = 1'b0; res_data = 32'd0;
        tick(2);
        areset = 1'b0;
        chk("rst_job_valid", 32'(job_valid), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_job_last", 32'(job_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd1);

        // 3x2 frame, always ready, 2-cycle core.
        jb = jobs_issued; bb = beats_seen;
        send_cfg(3, 2);
        chk("busy_after_cfg", 32'(busy), 32'd1);
        chk("job_valid_after_cfg", 32'(job_valid), 32'd1);
        wait_idle(200);
        chk("f32_jobs", 32'(jobs_issued - jb), 32'd6);
        chk("f32_beats", 32'(beats_seen - bb), 32'd6);
        chk("f32_s_tready", 32'(s_axis_tready), 32'd1);

        // Core never answers: issue stops at four outstanding.
        jb = jobs_issued; core_hold = 1'b1;
        send_cfg(4, 4);
        tick(20);
        chk("hold_jobs", 32'(jobs_issued - jb), 32'd4);
        chk("hold_job_valid", 32'(job_valid), 32'd0);
        core_hold = 1'b0;
        wait_idle(500);
        chk("hold_total_jobs", 32'(jobs_issued - jb), 32'd16);

        // Downstream stalls for 10 cycles with a beat pending.
        bb = beats_seen; m_axis_tready = 1'b0;
        send_cfg(2, 2);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin tick(1); n++; end
        chk("stall_beat_present", 32'(m_axis_tvalid), 32'd1);
        repeat (10) begin
            tick(1);
            chk("stall_res_ready", 32'(res_ready), 32'd0);
        end
        m_axis_tready = 1'b1;
        wait_idle(200);
        chk("stall_beats", 32'(beats_seen - bb), 32'd4);

        // Rejected configs.
        jb = jobs_issued;
        send_cfg(0, 5);
        chk("err0_pulse", 32'(cfg_err), 32'd1);
        chk("err0_busy", 32'(busy), 32'd0);
        tick(1);
        chk("err0_clear", 32'(cfg_err), 32'd0);
        send_cfg(641, 1);
        chk("err641_pulse", 32'(cfg_err), 32'd1);
        chk("err641_busy", 32'(busy), 32'd0);
        tick(1);
        chk("err641_clear", 32'(cfg_err), 32'd0);
        tick(5);
        chk("err_no_jobs", 32'(jobs_issued - jb), 32'd0);

        // Single-pixel frame.
        jb = jobs_issued; bb = beats_seen;
        send_cfg(1, 1);
        wait_idle(100);
        chk("f11_jobs", 32'(jobs_issued - jb), 32'd1);
        chk("f11_beats", 32'(beats_seen - bb), 32'd1);

        // Reset after three of six jobs, then a clean 2x1 frame.
        jb = jobs_issued;
        send_cfg(3, 2);
        n = 0;
        while (jobs_issued - jb < 3 && n < 100) begin tick(1); n++; end
        job_ready = 1'b0; areset = 1'b1;
        tick(1);
        chk("mid_jobs", 32'(jobs_issued - jb), 32'd3);
        chk("mid_job_valid", 32'(job_valid), 32'd0);
        chk("mid_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_s_tready", 32'(s_axis_tready), 32'd1);
        areset = 1'b0; job_ready = 1'b1;
        tick(2);
        jb = jobs_issued; bb = beats_seen;
        send_cfg(2, 1);
        wait_idle(100);
        chk("post_rst_jobs", 32'(jobs_issued - jb), 32'd2);
        chk("post_rst_beats", 32'(beats_seen - bb), 32'd2);

        // Random geometry, back-pressure and core latency.
        rand_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = int'($urandom_range(1, 6));
            h = int'($urandom_range(1, 4));
            bb = beats_seen;
            send_cfg(w, h);
            wait_idle(3000);
            chk("rand_beats", 32'(beats_seen - bb), 32'(w * h));
        end
        rand_mode = 1'b0;
        @(posedge aclk); #2;
        job_ready = 1'b1; m_axis_tready = 1'b1;
        tick(3);

        chk("job_q_empty", 32'(job_q.size()), 32'd0);
        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter MAX_WIDTH, default 640: largest accepted frame width in pixels.
REQ-002 Parameter MAX_HEIGHT, default 480: largest accepted frame height in pixels.
REQ-003 Parameter MAX_OUTSTANDING, default 4: maximum number of jobs issued whose results have not yet been accepted.
REQ-004 Ports SHALL be, in this order:
- aclk  in  1  sole clock; all logic on its rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  32  config word: [15:0] = width, [31:16] = height.
- s_axis_tvalid  in  1  config word valid.
- s_axis_tready  out  1  config word accepted.
- s_axis_tlast  in  1  ignored.
- job_x  out  16  pixel column of the issued job.
- job_y  out  16  pixel row of the issued job.
- job_last  out  1  marks the final job of the frame.
- job_valid  out  1  job offered to the compute core.
- job_ready  in  1  core accepts the job.
- res_data  in  32  pixel result from the core, returned in issue order.
- res_valid  in  1  result valid.
- res_ready  out  1  result accepted.
- m_axis_tdata  out  32  pixel output.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel of the frame.
- busy  out  1  high in any state other than IDLE.
- cfg_err  out  1  one-cycle pulse when a config word is rejected.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, ISSUE and DRAIN.
REQ-006 In IDLE, s_axis_tready SHALL be 1. In ISSUE and DRAIN it SHALL be 0.
REQ-007 On a config handshake in IDLE, width W and height H SHALL be latched.
REQ-008 If W=0, H=0, W>MAX_WIDTH or H>MAX_HEIGHT, the FSM SHALL remain in IDLE and cfg_err SHALL be 1 in the next cycle only.
REQ-009 For a valid config, the FSM SHALL enter ISSUE with x=0 and y=0, and job_valid SHALL rise in the cycle after the handshake.
REQ-010 While job_valid=1 and job_ready=0, job_x, job_y and job_last SHALL remain stable.
REQ-011 job_valid SHALL be 1 only in ISSUE and only when outstanding < MAX_OUTSTANDING. It SHALL deassert only after a job handshake.
REQ-012 Jobs SHALL be issued in raster order: x increments; when x=W-1, x wraps to 0 and y increments.
REQ-013 job_last SHALL be 1 for the job at (W-1, H-1).
REQ-014 On the job_last handshake, the FSM SHALL move to DRAIN.
REQ-015 The outstanding counter SHALL update as follows: +1 on a job handshake, -1 on a result handshake, unchanged when both occur in the same cycle. It SHALL never exceed MAX_OUTSTANDING or go below 0.
REQ-016 res_ready SHALL equal (state != IDLE) && (!m_axis_tvalid || m_axis_tready).
REQ-017 A result handshake SHALL load m_axis_tdata in the following cycle and set m_axis_tvalid, giving one cycle of latency.
REQ-018 m_axis_tvalid, m_axis_tdata and m_axis_tlast SHALL remain stable until m_axis_tready=1.
REQ-019 m_axis_tlast SHALL be 1 on the output beat for result number W*H-1, counting results from 0.
REQ-020 The FSM SHALL leave DRAIN for IDLE in the cycle after the m_axis_tlast beat handshakes. It SHALL clear busy then and accept the next config word.
REQ-021 The pixel counters SHALL be $clog2(MAX_WIDTH*MAX_HEIGHT+1) bits wide, and no counter SHALL wrap within a legal frame.
REQ-022 For W=H=1, exactly one job SHALL be issued, with job_last=1 and the FSM going directly to DRAIN.

Reset
REQ-023 While areset=1 at a rising edge of aclk, the FSM SHALL be set to IDLE and all counters to 0.
REQ-024 After reset, job_valid, m_axis_tvalid, m_axis_tlast, job_last, busy and cfg_err SHALL be 0, and s_axis_tready SHALL be 1.
REQ-025 Reset in the middle of a frame SHALL discard all in-flight jobs and results. The system SHALL reset the compute core in the same cycle.

Structure
REQ-026 Package frame_sched_pkg SHALL hold the state enum, the config field offsets (WIDTH_LSB=0, HEIGHT_LSB=16, FIELD_W=16) and the parameter defaults.
REQ-027 The output register (REQ-016 to REQ-018) SHALL be a sub-module named axis_out_reg.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Config W=3, H=2, with job_ready and m_axis_tready held at 1 and a core with 2-cycle latency: jobs (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); job_last is set only on (2,1); 6 output beats with tlast only on the 6th; busy falls afterwards.
- Core that never returns results: exactly MAX_OUTSTANDING=4 jobs issued, then job_valid stays 0.
- m_axis_tready held at 0 for 10 cycles while a result is pending: output beat stays stable, res_ready=0, no data lost.
- Config W=0, H=5, then W=641, H=1: a cfg_err pulse for each, busy stays 0, no jobs issued.
- Config W=1, H=1: exactly one job with job_last=1, and one output beat with tlast=1.
- areset=1 after 3 of 6 jobs issued: all outputs at reset values next cycle, and a fresh config W=2, H=1 runs cleanly afterwards.
